ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arb_rr_sel.sv | 19 +
 rtl/ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ==========================================================================
// ram_arb_pkg : shared types and constants for the two-port RAM arbiter
// Rev 1.0
// ==========================================================================
package ram_arb_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr_sel.sv
`default_nettype none
// ==========================================================================
// ram_arb_rr_sel : two-way round-robin pick, one-hot select from valids
// Rev 1.0
// ==========================================================================
module ram_arb_rr_sel (
  input  logic [1:0] valid_i,
  input  logic       last_i,   // 1: req1 was served last, so req0 has priority
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o    = 2'b00;
    sel_o[0] = valid_i[0] & (~valid_i[1] | last_i);
    sel_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);
  end

endmodule : ram_arb_rr_sel
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ==========================================================================
// ram_arbiter : two requesters sharing one single-port RAM with locking
// Optional forced lock release when ARB_TIMEOUT_EN is defined.  Rev 1.0
// ==========================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  req0_din,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_dout,
  output logic              req0_tx_valid,
  input  logic [CMD_W-1:0]  req1_din,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_dout,
  output logic              req1_tx_valid,
  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CMD_W-1:0]    ram_din_q, ram_din_d;
  logic                ram_rx_valid_q, ram_rx_valid_d;
  logic [DATA_W-1:0]   dout0_q, dout0_d, dout1_q, dout1_d;
  logic                tx0_q, tx0_d, tx1_q, tx1_d;
  logic [1:0]          rr_sel;
  logic                acc0, acc1, acc, acc_id, rd_done;
  logic [CMD_W-1:0]    acc_word;

  // Counter must be able to represent LOCK_TIMEOUT; an empty block marks the check.
  if (2**CNT_W <= LOCK_TIMEOUT) begin : g_cnt_w_too_small
  end

  ram_arb_rr_sel u_rr_sel (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .sel_o   (rr_sel)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    dout0_d        = dout0_q;
    dout1_d        = dout1_q;
    tx0_d          = 1'b0;
    tx1_d          = 1'b0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req0_ready = rr_sel[0];
        req1_ready = rr_sel[1];
      end
      ST_LOCKED: begin
        req0_ready = ~owner_q;
        req1_ready = owner_q;
      end
      default: ;
    endcase

    acc0     = req0_valid & req0_ready;
    acc1     = req1_valid & req1_ready;
    acc      = acc0 | acc1;
    acc_id   = acc1;
    acc_word = acc1 ? req1_din : req0_din;
    rd_done  = (state_q == ST_WAIT_RD) & ram_tx_valid;

    if (acc) begin
      ram_din_d      = acc_word;
      ram_rx_valid_d = 1'b1;
      owner_d        = acc_id;
      case (acc_word[9:8])
        OP_WR_ADDR, OP_RD_ADDR: state_d = ST_LOCKED;
        OP_RD_DATA:             state_d = ST_WAIT_RD;
        default: begin
          state_d = ST_IDLE;
          last_d  = acc_id;
        end
      endcase
    end else if (rd_done) begin
      state_d = ST_IDLE;
      last_d  = owner_q;
      if (owner_q) begin
        dout1_d = ram_dout;
        tx1_d   = 1'b1;
      end else begin
        dout0_d = ram_dout;
        tx0_d   = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  state_e           state_nxt;
  logic             last_nxt;

  // Idle-hold timer overrides the normal next state only when nothing progressed.
  always_comb begin
    cnt_d     = '0;
    err_d     = 1'b0;
    state_nxt = state_d;
    last_nxt  = last_d;
    if (state_q != ST_IDLE && !acc && !rd_done) begin
      if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
        state_nxt = ST_IDLE;
        last_nxt  = owner_q;
        err_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  state_e state_nxt;
  logic   last_nxt;

  assign state_nxt   = state_d;
  assign last_nxt    = last_d;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      dout0_q        <= '0;
      dout1_q        <= '0;
      tx0_q          <= 1'b0;
      tx1_q          <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      owner_q        <= owner_d;
      last_q         <= last_nxt;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      dout0_q        <= dout0_d;
      dout1_q        <= dout1_d;
      tx0_q          <= tx0_d;
      tx1_q          <= tx1_d;
    end
  end

  assign ram_din       = ram_din_q;
  assign ram_rx_valid  = ram_rx_valid_q;
  assign req0_dout     = dout0_q;
  assign req1_dout     = dout1_q;
  assign req0_tx_valid = tx0_q;
  assign req1_tx_valid = tx1_q;
  assign grant         = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_ram_arbiter : scoreboard bench for ram_arbiter (RAM commands, read returns)
// Rev 1.0
// ==========================================================================
module tb_ram_arbiter;

  localparam int LOCK_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] req0_din, req1_din;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_dout, req1_dout;
  logic       req0_tx_valid, req1_tx_valid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic [1:0] grant;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q_ram[$];
  logic [8:0] q_rd[$];   // {port, data}

  always #5 clk = ~clk;

  ram_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(7)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_din(req0_din), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dout(req0_dout), .req0_tx_valid(req0_tx_valid),
    .req1_din(req1_din), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dout(req1_dout), .req1_tx_valid(req1_tx_valid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every DUT strobe is matched against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (ram_rx_valid) begin
      if (q_ram.size() == 0) check_eq("ram_unexpected", 1, 0);
      else check_eq("ram_din", ram_din, q_ram.pop_front());
    end
    if (req0_tx_valid || req1_tx_valid) begin
      if (q_rd.size() == 0) check_eq("rd_unexpected", {req1_tx_valid, req0_tx_valid}, 0);
      else begin
        logic [8:0] e;
        e = q_rd.pop_front();
        check_eq("rd_port", {req1_tx_valid, req0_tx_valid}, e[8] ? 2'b10 : 2'b01);
        check_eq("rd_data", e[8] ? req1_dout : req0_dout, e[7:0]);
      end
    end
  end

  task automatic send(input bit p, input logic [9:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (p) begin req1_din = w; req1_valid = 1'b1; end
    else   begin req0_din = w; req0_valid = 1'b1; end
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin
        q_ram.push_back(w);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    check_eq(p ? "accept1" : "accept0", ok, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_din = '0; req1_din = '0; req0_valid = 1'b0; req1_valid = 1'b0;
    ram_dout = '0; ram_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_outs"},
             {grant, ram_rx_valid, ram_din, req0_tx_valid, req1_tx_valid,
              req0_dout, req1_dout, timeout_err}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit flag;
    int n;
    do_reset();
    check_reset_outputs("reset");

    // Write address then data from req0: lock, then release
    send(0, 10'h005);
    #1 check_eq("grant_wr_lock", grant, 2'b01);
    send(0, 10'h1A5);
    #1 check_eq("grant_wr_free", grant, 2'b00);

    // Read sequence, RAM answers 0x51
    send(0, 10'h205);
    send(0, 10'h300);
    req1_valid = 1'b1; req1_din = 10'h005;
    #1 check_eq("grant_wait_rd", grant, 2'b01);
    check_eq("ready_wait_rd", {req1_ready, req0_ready}, 2'b00);
    req1_valid = 1'b0;
    @(negedge clk);
    ram_dout = 8'h51; ram_tx_valid = 1'b1;
    q_rd.push_back({1'b0, 8'h51});
    @(negedge clk);
    ram_tx_valid = 1'b0;
    check_eq("grant_after_rd", grant, 2'b00);

    // RAM data while idle must not reach anyone
    ram_dout = 8'h77; ram_tx_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("ign_tx", {req1_tx_valid, req0_tx_valid}, 2'b00);
    check_eq("dout0_hold", req0_dout, 8'h51);
    @(negedge clk) ram_tx_valid = 1'b0;

    // Round robin after a fresh reset
    do_reset();
    @(negedge clk);
    req0_din = 10'h005; req0_valid = 1'b1;
    req1_din = 10'h010; req1_valid = 1'b1;
    #1 check_eq("rr_first", {req1_ready, req0_ready}, 2'b01);
    q_ram.push_back(10'h005);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check_eq("rr_locked", {req1_ready, grant}, {1'b0, 2'b01});
    req0_din = 10'h1BB; req0_valid = 1'b1;
    #1 q_ram.push_back(10'h1BB);
    @(negedge clk);
    req0_din = 10'h011;
    #1 check_eq("rr_second", {req1_ready, req0_ready}, 2'b10);
    q_ram.push_back(10'h010);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 check_eq("grant_req1", grant, 2'b10);

    // req1 holds the lock while req0 keeps asking
    req0_din = 10'h033;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      flag |= req0_ready;
    end
    check_eq("lock_blocks_req0", flag, 0);
    send(1, 10'h1CC);
    #1 check_eq("req0_after_release", req0_ready, 1);
    q_ram.push_back(10'h033);
    @(negedge clk);
    req0_valid = 1'b0;
    send(0, 10'h100);

    // Reset while waiting for read data
    send(0, 10'h2AA);
    send(0, 10'h3AA);
    #1 check_eq("pre_reset_grant", grant, 2'b01);
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    ram_dout = 8'hEE; ram_tx_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    ram_tx_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");

    // Lock held with no traffic
    send(0, 10'h010);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (timeout_err) break;
    end
    check_eq("timeout_latency", n, LOCK_TIMEOUT);
    check_eq("timeout_grant", grant, 2'b00);
    @(posedge clk); #1;
    check_eq("timeout_pulse", timeout_err, 0);
    send(1, 10'h020);
    #1 check_eq("grant_after_to", grant, 2'b10);
    send(1, 10'h100);
`else
    flag = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      flag |= timeout_err;
      n++;
    end
    check_eq("no_timeout", flag, 0);
    check_eq("lock_kept", grant, 2'b01);
    send(0, 10'h100);
`endif

    repeat (3) @(negedge clk);
    check_eq("ram_q_empty", q_ram.size(), 0);
    check_eq("rd_q_empty", q_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
